spi_slave_multimode: RTL and testbench
======================================

Name: spi_slave_multimode

Overview:
- Parametrised SPI target that replaces the fixed 8-bit, single-mode slave used on the FPGA link from the host camera/MCU side.
- Oversamples an external SPI bus with the system clock and supports all four CPOL/CPHA modes, configurable word width and bit order.
- Provides full-duplex word exchange over valid/ready-style handshakes to the face-recognition datapath.
- Supports back-to-back words within one chip-select frame.

Parameters:
- DATA_W, 8: bits per SPI word (4..32).
- CPOL, 0: idle level of i_sclk.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first, 0 = LSB first.
- SYNC_STAGES, 2: synchroniser flops on i_sclk, i_ss and i_mosi (min 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_sclk  in  1  SPI clock, asynchronous to clk; max frequency is clk/8.
- i_ss  in  1  chip select, active low.
- i_mosi  in  1  master-out data.
- o_miso  out  1  slave-out data; 0 when not driving.
- o_miso_oe  out  1  tri-state enable; 1 only while synchronised ss is low.
- i_tx_data  in  DATA_W  next word to transmit.
- i_tx_valid  in  1  tx word offered.
- o_tx_ready  out  1  one-entry tx holding register empty.
- o_rx_data  out  DATA_W  last completed received word; holds until the next word completes.
- o_rx_valid  out  1  one-clk pulse when o_rx_data updates.
- o_tx_underrun  out  1  one-clk pulse when a word starts with the holding register empty.
- o_busy  out  1  synchronised ss low.

Behaviour:
- Reset:
  - All outputs are 0 except o_tx_ready = 1.
  - Holding register empty; bit counter 0; shift registers 0; synchronisers loaded with idle values (sclk = CPOL, ss = 1, mosi = 0).
- Synchronisation and edge detection:
  - Edges are detected on synchronised i_sclk, one clk after the synchroniser output changes.
  - Sample edge is rising when CPOL == CPHA, otherwise falling. Shift edge is the opposite edge.
  - Edges on i_sclk are ignored while synchronised ss is high.
- TX holding register:
  - A transfer is accepted when i_tx_valid && o_tx_ready.
  - o_tx_ready goes low the clk after acceptance.
  - o_tx_ready returns high the clk after the holding register is moved into the tx shift register.
- Word load points are the ss falling edge (synchronised) and the sample edge that completes a word while ss stays low. At each load point:
  - Holding full: the shift register takes the holding register, which is then emptied.
  - Holding empty: the shift register loads all zeros and o_tx_underrun pulses.
  - If acceptance and load occur in the same clk, the load uses the prior holding state. An accepted word that arrives at that moment is kept for the next word.
- MISO timing:
  - CPHA = 0, first word: the first bit is driven within 1 clk of the ss-start load.
  - Every subsequent bit, including the first bit of following words, is driven on a shift edge.
  - CPHA = 1: every bit is driven on a shift edge, starting with the first leading edge.
- RX:
  - On each sample edge, the synchronised mosi enters the rx shift register according to MSB_FIRST.
  - The bit counter runs 0..DATA_W-1 and wraps to 0 on the DATA_W-th sample.
  - On wrap, o_rx_data is updated and o_rx_valid pulses in the following clk. There is no backpressure; the consumer must take the word in that cycle.
- SS deasserted mid-word:
  - Bit counter is cleared and the partial rx word is discarded (no o_rx_valid).
  - The tx shift contents are discarded; a consumed holding word is not restored.
  - o_miso_oe = 0 and o_miso = 0 within 1 clk of synchronised ss rising.
- SS deasserted exactly after a word completes: o_rx_valid still pulses for that word.
- i_rst mid-transfer: immediately returns the block to reset state. Bus activity is ignored until the next synchronised ss falling edge.

Test Plan:
- Mode 0, DATA_W = 8, MSB_FIRST = 1:
  - Stimulus: preload tx 0xA5; master sends 0xAA at clk/10.
  - Required: o_rx_data = 0xAA with one o_rx_valid pulse; master captures 0xA5; o_tx_underrun never pulses.
- Mode 3, DATA_W = 16:
  - Stimulus: one ss frame with two back-to-back words; tx 0x1234, then 0xBEEF written when o_tx_ready reasserts; master sends 0x0F0F, 0xF00F.
  - Required: two o_rx_valid pulses with 0x0F0F then 0xF00F; master captures 0x1234 then 0xBEEF.
- Underrun, mode 1:
  - Stimulus: ss falls with the holding register empty.
  - Required: o_tx_underrun pulses once; master captures 0x00; rx still completes normally.
- Abort:
  - Stimulus: ss rises after 3 bits of 0xC3.
  - Required: no o_rx_valid; o_miso_oe = 0. A following full frame with 0x5A yields o_rx_data = 0x5A, not corrupted by the aborted bits.
- LSB first (MSB_FIRST = 0, mode 2):
  - Stimulus: master sends bit stream 1,0,0,0,0,0,0,0.
  - Required: o_rx_data = 0x01; tx 0x80 appears on MISO as its LSB first, bit stream 0,...,0,1.
- Reset mid-word:
  - Stimulus: assert i_rst for 1 clk after 4 bits.
  - Required: all outputs at reset values; o_tx_ready = 1; the next complete frame with 0x3C returns o_rx_data = 0x3C.

Source files
------------

// File: rtl/spi_slave_multimode_if.sv
// Bus bundle for spi_slave_multimode: external SPI pins plus the tx/rx word
// handshakes toward the datapath.
interface spi_slave_multimode_if #(
    parameter int DATA_W = 8
);
    logic              i_sclk;
    logic              i_ss;
    logic              i_mosi;
    logic              o_miso;
    logic              o_miso_oe;
    logic [DATA_W-1:0] i_tx_data;
    logic              i_tx_valid;
    logic              o_tx_ready;
    logic [DATA_W-1:0] o_rx_data;
    logic              o_rx_valid;
    logic              o_tx_underrun;
    logic              o_busy;

    modport slave (
        input  i_sclk, i_ss, i_mosi, i_tx_data, i_tx_valid,
        output o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_tx_underrun, o_busy
    );

    modport master (
        output i_sclk, i_ss, i_mosi, i_tx_data, i_tx_valid,
        input  o_miso, o_miso_oe, o_tx_ready, o_rx_data, o_rx_valid, o_tx_underrun, o_busy
    );
endinterface

// File: rtl/spi_slave_multimode.sv
// Oversampled SPI target: all four CPOL/CPHA modes, configurable width and bit
// order, one-entry tx holding register and back-to-back words per frame.
module spi_slave_multimode #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input logic                  clk,
    input logic                  i_rst,
    spi_slave_multimode_if.slave bus
);
    localparam int   CW          = $clog2(DATA_W);
    localparam logic IDLE_SCLK   = (CPOL != 0);
    localparam bit   SAMPLE_RISE = (CPOL == CPHA);
    localparam bit   MSB         = (MSB_FIRST != 0);

    logic [SYNC_STAGES-1:0] sclk_pipe, ss_pipe, mosi_pipe, fill_pipe;
    logic                   sclk_s, ss_s, mosi_s, fill_done;

    logic              sclk_d_reg, ss_d_reg, armed_reg, in_frame_reg;
    logic [CW-1:0]     bit_cnt_reg;
    logic [DATA_W-1:0] rx_shift_reg, rx_data_reg, tx_shift_reg, hold_data_reg;
    logic              hold_full_reg, rx_valid_reg, underrun_reg, pend_underrun_reg;
    logic              miso_reg, oe_reg;

    logic              ss_fall, frame, frame_next, sclk_rise, sclk_fall;
    logic              sample_edge, shift_edge, word_done, load, accept;
    logic [DATA_W-1:0] load_word, rx_next, tx_shifted, ld_shifted;
    logic              tx_head, ld_head;

    // fill_pipe tracks when the synchroniser holds real samples after reset
    always_ff @(posedge clk) begin
        if (i_rst) begin
            sclk_pipe <= {SYNC_STAGES{IDLE_SCLK}};
            ss_pipe   <= '1;
            mosi_pipe <= '0;
            fill_pipe <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], bus.i_sclk};
            ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], bus.i_ss};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], bus.i_mosi};
            fill_pipe <= {fill_pipe[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
    assign ss_s      = ss_pipe[SYNC_STAGES-1];
    assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
    assign fill_done = fill_pipe[SYNC_STAGES-1];

    assign ss_fall     = armed_reg & ss_d_reg & ~ss_s;
    assign frame       = in_frame_reg & ~ss_s;
    assign frame_next  = ~ss_s & (in_frame_reg | ss_fall);
    assign sclk_rise   = sclk_s & ~sclk_d_reg;
    assign sclk_fall   = ~sclk_s & sclk_d_reg;
    assign sample_edge = frame & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign shift_edge  = frame & (SAMPLE_RISE ? sclk_fall : sclk_rise);
    assign word_done   = sample_edge & (bit_cnt_reg == CW'(DATA_W - 1));
    assign load        = ss_fall | word_done;
    assign accept      = bus.i_tx_valid & ~hold_full_reg;
    assign load_word   = hold_full_reg ? hold_data_reg : '0;

    assign rx_next    = MSB ? {rx_shift_reg[DATA_W-2:0], mosi_s} : {mosi_s, rx_shift_reg[DATA_W-1:1]};
    assign tx_head    = MSB ? tx_shift_reg[DATA_W-1] : tx_shift_reg[0];
    assign tx_shifted = MSB ? {tx_shift_reg[DATA_W-2:0], 1'b0} : {1'b0, tx_shift_reg[DATA_W-1:1]};
    assign ld_head    = MSB ? load_word[DATA_W-1] : load_word[0];
    assign ld_shifted = MSB ? {load_word[DATA_W-2:0], 1'b0} : {1'b0, load_word[DATA_W-1:1]};

    always_ff @(posedge clk) begin
        if (i_rst) begin
            sclk_d_reg        <= IDLE_SCLK;
            ss_d_reg          <= 1'b1;
            armed_reg         <= 1'b0;
            in_frame_reg      <= 1'b0;
            bit_cnt_reg       <= '0;
            rx_shift_reg      <= '0;
            rx_data_reg       <= '0;
            tx_shift_reg      <= '0;
            hold_data_reg     <= '0;
            hold_full_reg     <= 1'b0;
            rx_valid_reg      <= 1'b0;
            underrun_reg      <= 1'b0;
            pend_underrun_reg <= 1'b0;
            miso_reg          <= 1'b0;
            oe_reg            <= 1'b0;
        end else begin
            sclk_d_reg   <= sclk_s;
            ss_d_reg     <= ss_s;
            armed_reg    <= armed_reg | (fill_done & ss_s);
            in_frame_reg <= frame_next;
            oe_reg       <= frame_next;
            rx_valid_reg <= 1'b0;
            underrun_reg <= 1'b0;

            // A word accepted in the same clk as a load waits for the next word
            if (accept) begin
                hold_full_reg <= 1'b1;
                hold_data_reg <= bus.i_tx_data;
            end else if (load) begin
                hold_full_reg <= 1'b0;
            end

            if (ss_s) begin
                bit_cnt_reg       <= '0;
                rx_shift_reg      <= '0;
                tx_shift_reg      <= '0;
                pend_underrun_reg <= 1'b0;
                miso_reg          <= 1'b0;
            end else if (ss_fall) begin
                bit_cnt_reg       <= '0;
                underrun_reg      <= ~hold_full_reg;
                pend_underrun_reg <= 1'b0;
                if (CPHA == 0) begin
                    miso_reg     <= ld_head;
                    tx_shift_reg <= ld_shifted;
                end else begin
                    tx_shift_reg <= load_word;
                end
            end else begin
                if (sample_edge) begin
                    rx_shift_reg <= rx_next;
                    // An empty back-to-back load only counts once its word is clocked
                    if (bit_cnt_reg == '0 && pend_underrun_reg) begin
                        underrun_reg      <= 1'b1;
                        pend_underrun_reg <= 1'b0;
                    end
                    if (word_done) begin
                        bit_cnt_reg       <= '0;
                        rx_data_reg       <= rx_next;
                        rx_valid_reg      <= 1'b1;
                        tx_shift_reg      <= load_word;
                        pend_underrun_reg <= ~hold_full_reg;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                if (shift_edge) begin
                    miso_reg     <= tx_head;
                    tx_shift_reg <= tx_shifted;
                end
            end
        end
    end

    assign bus.o_miso        = miso_reg;
    assign bus.o_miso_oe     = oe_reg;
    assign bus.o_busy        = oe_reg;
    assign bus.o_tx_ready    = ~hold_full_reg;
    assign bus.o_rx_data     = rx_data_reg;
    assign bus.o_rx_valid    = rx_valid_reg;
    assign bus.o_tx_underrun = underrun_reg;
endmodule

// File: tb/tb_spi_slave_multimode.sv
// Directed bench: four instances (modes 0, 3, 1 and LSB-first mode 2) driven by
// one bit-banged master; sclk runs at clk/10.
module tb_spi_slave_multimode;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        raw = 1'b0;
    logic        mosi = 1'b0;
    logic [3:0]  ss = 4'hF;
    logic [3:0]  tx_valid = 4'h0;
    logic [31:0] tx_data [4] = '{default: '0};

    logic [3:0]  miso_w, oe_w, busy_w, ready_w, rxv_w, ur_w;
    logic [31:0] rxd_w [4];

    int          rx_cnt [4] = '{default: 0};
    int          ur_cnt [4] = '{default: 0};
    logic [31:0] rx_last [4] = '{default: '0};
    logic [31:0] rx_prev [4] = '{default: '0};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_slave_multimode_if #(.DATA_W(8))  if0 ();
    spi_slave_multimode_if #(.DATA_W(16)) if1 ();
    spi_slave_multimode_if #(.DATA_W(8))  if2 ();
    spi_slave_multimode_if #(.DATA_W(8))  if3 ();

    spi_slave_multimode #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(2))
        dut0 (.clk(clk), .i_rst(rst), .bus(if0.slave));
    spi_slave_multimode #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2))
        dut1 (.clk(clk), .i_rst(rst), .bus(if1.slave));
    spi_slave_multimode #(.DATA_W(8), .CPOL(0), .CPHA(1), .MSB_FIRST(1), .SYNC_STAGES(2))
        dut2 (.clk(clk), .i_rst(rst), .bus(if2.slave));
    spi_slave_multimode #(.DATA_W(8), .CPOL(1), .CPHA(0), .MSB_FIRST(0), .SYNC_STAGES(2))
        dut3 (.clk(clk), .i_rst(rst), .bus(if3.slave));

    // raw is the "active" clock; each instance sees it XOR its CPOL
    assign if0.i_sclk = raw;   assign if0.i_ss = ss[0]; assign if0.i_mosi = mosi;
    assign if1.i_sclk = ~raw;  assign if1.i_ss = ss[1]; assign if1.i_mosi = mosi;
    assign if2.i_sclk = raw;   assign if2.i_ss = ss[2]; assign if2.i_mosi = mosi;
    assign if3.i_sclk = ~raw;  assign if3.i_ss = ss[3]; assign if3.i_mosi = mosi;
    assign if0.i_tx_data = tx_data[0][7:0];  assign if0.i_tx_valid = tx_valid[0];
    assign if1.i_tx_data = tx_data[1][15:0]; assign if1.i_tx_valid = tx_valid[1];
    assign if2.i_tx_data = tx_data[2][7:0];  assign if2.i_tx_valid = tx_valid[2];
    assign if3.i_tx_data = tx_data[3][7:0];  assign if3.i_tx_valid = tx_valid[3];

    assign {miso_w[0], oe_w[0], busy_w[0], ready_w[0], rxv_w[0], ur_w[0]} =
           {if0.o_miso, if0.o_miso_oe, if0.o_busy, if0.o_tx_ready, if0.o_rx_valid, if0.o_tx_underrun};
    assign {miso_w[1], oe_w[1], busy_w[1], ready_w[1], rxv_w[1], ur_w[1]} =
           {if1.o_miso, if1.o_miso_oe, if1.o_busy, if1.o_tx_ready, if1.o_rx_valid, if1.o_tx_underrun};
    assign {miso_w[2], oe_w[2], busy_w[2], ready_w[2], rxv_w[2], ur_w[2]} =
           {if2.o_miso, if2.o_miso_oe, if2.o_busy, if2.o_tx_ready, if2.o_rx_valid, if2.o_tx_underrun};
    assign {miso_w[3], oe_w[3], busy_w[3], ready_w[3], rxv_w[3], ur_w[3]} =
           {if3.o_miso, if3.o_miso_oe, if3.o_busy, if3.o_tx_ready, if3.o_rx_valid, if3.o_tx_underrun};
    assign rxd_w[0] = 32'(if0.o_rx_data);
    assign rxd_w[1] = 32'(if1.o_rx_data);
    assign rxd_w[2] = 32'(if2.o_rx_data);
    assign rxd_w[3] = 32'(if3.o_rx_data);

    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (rxv_w[d]) begin
                rx_cnt[d]  <= rx_cnt[d] + 1;
                rx_prev[d] <= rx_last[d];
                rx_last[d] <= rxd_w[d];
                $display("[TB] dut%0d rx word 0x%0h", d, rxd_w[d]);
            end
            if (ur_w[d]) ur_cnt[d] <= ur_cnt[d] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [31:0] v);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!ready_w[d] && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("tx_ready_wait", 32'(ready_w[d]), 32'd1);
        tx_data[d]  = v;
        tx_valid[d] = 1'b1;
        @(negedge clk);
        tx_valid[d] = 1'b0;
        $display("[TB] dut%0d tx push 0x%0h", d, v);
    endtask

    task automatic shift_bits(input int d, input int cpha, input int dw, input int nbits,
                              input bit msb, input logic [31:0] mo, output logic [31:0] mi);
        mi = '0;
        for (int b = 0; b < nbits; b++) begin
            int bi;
            bi = msb ? dw - 1 - b : b;
            if (cpha == 0) begin
                mosi = mo[bi];
                #50;
                mi[bi] = miso_w[d];
                raw = 1'b1;
                #50;
                raw = 1'b0;
            end else begin
                raw  = 1'b1;
                mosi = mo[bi];
                #50;
                mi[bi] = miso_w[d];
                raw = 1'b0;
                #50;
            end
        end
        $display("[TB] dut%0d shifted %0d bits out 0x%0h in 0x%0h", d, nbits, mo, mi);
    endtask

    initial begin
        logic [31:0] mi0, mi1;
        int b_rx, b_ur;

        // Reset values
        repeat (4) @(negedge clk);
        rst = 1'b0;
        check("rst_miso", 32'(miso_w[0]), 32'd0);
        check("rst_oe", 32'(oe_w[0]), 32'd0);
        check("rst_busy", 32'(busy_w[0]), 32'd0);
        check("rst_ready", 32'(ready_w[0]), 32'd1);
        check("rst_rx_valid", 32'(rxv_w[0]), 32'd0);
        check("rst_underrun", 32'(ur_w[0]), 32'd0);
        check("rst_rx_data", rxd_w[0], 32'h0);
        repeat (10) @(negedge clk);

        // Mode 0, one word
        b_rx = rx_cnt[0]; b_ur = ur_cnt[0];
        push(0, 32'hA5);
        check("m0_ready_low", 32'(ready_w[0]), 32'd0);
        ss[0] = 1'b0;
        #100;
        check("m0_oe_on", 32'(oe_w[0]), 32'd1);
        check("m0_busy_on", 32'(busy_w[0]), 32'd1);
        shift_bits(0, 0, 8, 8, 1'b1, 32'hAA, mi0);
        #100; ss[0] = 1'b1; #100;
        check("m0_rx_data", rx_last[0], 32'hAA);
        check("m0_rx_count", 32'(rx_cnt[0] - b_rx), 32'd1);
        check("m0_miso_word", mi0, 32'hA5);
        check("m0_underrun", 32'(ur_cnt[0] - b_ur), 32'd0);

        // Mode 3, two back-to-back 16-bit words
        b_rx = rx_cnt[1]; b_ur = ur_cnt[1];
        push(1, 32'h1234);
        ss[1] = 1'b0;
        push(1, 32'hBEEF);
        #100;
        shift_bits(1, 1, 16, 16, 1'b1, 32'h0F0F, mi0);
        shift_bits(1, 1, 16, 16, 1'b1, 32'hF00F, mi1);
        #100; ss[1] = 1'b1; #100;
        check("m3_rx_count", 32'(rx_cnt[1] - b_rx), 32'd2);
        check("m3_rx_first", rx_prev[1], 32'h0F0F);
        check("m3_rx_second", rx_last[1], 32'hF00F);
        check("m3_miso_first", mi0, 32'h1234);
        check("m3_miso_second", mi1, 32'hBEEF);
        check("m3_underrun", 32'(ur_cnt[1] - b_ur), 32'd0);

        // Mode 1, frame starts with holding register empty
        b_rx = rx_cnt[2]; b_ur = ur_cnt[2];
        ss[2] = 1'b0;
        #100;
        shift_bits(2, 1, 8, 8, 1'b1, 32'h96, mi0);
        #100; ss[2] = 1'b1; #100;
        check("ur_count", 32'(ur_cnt[2] - b_ur), 32'd1);
        check("ur_miso_word", mi0, 32'h00);
        check("ur_rx_data", rx_last[2], 32'h96);
        check("ur_rx_count", 32'(rx_cnt[2] - b_rx), 32'd1);

        // Abort after 3 bits, then a clean frame
        b_rx = rx_cnt[0];
        ss[0] = 1'b0;
        #100;
        shift_bits(0, 0, 8, 3, 1'b1, 32'hC3, mi0);
        ss[0] = 1'b1;
        #60;
        check("abort_oe", 32'(oe_w[0]), 32'd0);
        check("abort_miso", 32'(miso_w[0]), 32'd0);
        #100;
        check("abort_no_rx", 32'(rx_cnt[0] - b_rx), 32'd0);
        ss[0] = 1'b0;
        #100;
        shift_bits(0, 0, 8, 8, 1'b1, 32'h5A, mi0);
        #100; ss[0] = 1'b1; #100;
        check("abort_next_rx", rx_last[0], 32'h5A);
        check("abort_next_count", 32'(rx_cnt[0] - b_rx), 32'd1);

        // LSB first, mode 2
        b_rx = rx_cnt[3];
        push(3, 32'h80);
        ss[3] = 1'b0;
        #100;
        shift_bits(3, 0, 8, 8, 1'b0, 32'h01, mi0);
        #100; ss[3] = 1'b1; #100;
        check("lsb_rx_data", rx_last[3], 32'h01);
        check("lsb_rx_count", 32'(rx_cnt[3] - b_rx), 32'd1);
        check("lsb_miso_word", mi0, 32'h80);

        // Reset after 4 bits with a word still held
        b_rx = rx_cnt[0];
        push(0, 32'h99);
        ss[0] = 1'b0;
        push(0, 32'h11);
        #100;
        shift_bits(0, 0, 8, 4, 1'b1, 32'hFF, mi0);
        check("rstmid_ready_before", 32'(ready_w[0]), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rstmid_ready", 32'(ready_w[0]), 32'd1);
        check("rstmid_oe", 32'(oe_w[0]), 32'd0);
        check("rstmid_busy", 32'(busy_w[0]), 32'd0);
        check("rstmid_miso", 32'(miso_w[0]), 32'd0);
        check("rstmid_rx_data", rxd_w[0], 32'h0);
        check("rstmid_underrun", 32'(ur_w[0]), 32'd0);
        shift_bits(0, 0, 8, 4, 1'b1, 32'hFF, mi0);
        check("rstmid_ignored_oe", 32'(oe_w[0]), 32'd0);
        #100; ss[0] = 1'b1; #100;
        check("rstmid_no_rx", 32'(rx_cnt[0] - b_rx), 32'd0);
        ss[0] = 1'b0;
        #100;
        shift_bits(0, 0, 8, 8, 1'b1, 32'h3C, mi0);
        #100; ss[0] = 1'b1; #100;
        check("rstmid_next_rx", rx_last[0], 32'h3C);
        check("rstmid_next_count", 32'(rx_cnt[0] - b_rx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
